// File: rtl/test_rd_ctrl_chk_pkg.sv
// Shared definitions for the DDR test read-side checker: FSM state
// encodings, beat address stride and the default fixed-pattern bytes.
package test_rd_ctrl_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } rd_state_e;

  localparam int unsigned BEAT_ADDR_STRIDE = 8;
  localparam int unsigned NUM_GROUPS       = 8;

  localparam logic [7:0] DEF_PATTERN0 = 8'h55;
  localparam logic [7:0] DEF_PATTERN1 = 8'haa;
  localparam logic [7:0] DEF_PATTERN2 = 8'h7f;
  localparam logic [7:0] DEF_PATTERN3 = 8'h80;
  localparam logic [7:0] DEF_PATTERN4 = 8'h55;
  localparam logic [7:0] DEF_PATTERN5 = 8'haa;
  localparam logic [7:0] DEF_PATTERN6 = 8'h7f;
  localparam logic [7:0] DEF_PATTERN7 = 8'h80;

endpackage

// File: rtl/test_rd_ctrl_chk_prbs.sv
// PRBS15 (x^15 + x^14 + 1) generator producing 64 fresh bits per advance.
// Used by test_rd_ctrl_chk only when RD_PRBS_CHK_EN is defined.
module prbs15_64bit_v1_0 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [63:0] prbs_dout
);

  logic [14:0] lfsr;
  logic [14:0] lfsr_next;

  // Run the LFSR 64 steps: low 15 bits are the next state, upper 64 the output bits
  function automatic logic [78:0] step64(input logic [14:0] s_in);
    logic [14:0] s;
    logic [63:0] d;
    logic        fb;
    s = s_in;
    d = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      fb   = s[14] ^ s[13];
      d[k] = fb;
      s    = {s[13:0], fb};
    end
    return {d, s};
  endfunction

  // Output bits for the current beat and the state after it
  always_comb begin
    {prbs_dout, lfsr_next} = step64(lfsr);
  end

  // Seed on load (a zero seed would lock up, so bit 0 is forced then), advance per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 15'h1;
    end else if (load) begin
      lfsr <= (seed[14:0] == '0) ? {seed[15], 13'b0, 1'b1} : seed[14:0];
    end else if (advance) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/test_rd_ctrl_chk.sv
// DDR test read-side engine: issues one AXI read burst at a time, regenerates
// the expected data for every returned beat, compares it through a two-stage
// pipeline and keeps sticky error status.
// Optional feature: define RD_PRBS_CHK_EN to compare against PRBS15 data
// (seeded from araddr[15:0]) instead of incrementing-address bytes when
// pattern_en is low.
module test_rd_ctrl_chk
  import test_rd_ctrl_chk_pkg::*;
#(
  parameter logic [7:0]  DATA_PATTERN0   = DEF_PATTERN0,
  parameter logic [7:0]  DATA_PATTERN1   = DEF_PATTERN1,
  parameter logic [7:0]  DATA_PATTERN2   = DEF_PATTERN2,
  parameter logic [7:0]  DATA_PATTERN3   = DEF_PATTERN3,
  parameter logic [7:0]  DATA_PATTERN4   = DEF_PATTERN4,
  parameter logic [7:0]  DATA_PATTERN5   = DEF_PATTERN5,
  parameter logic [7:0]  DATA_PATTERN6   = DEF_PATTERN6,
  parameter logic [7:0]  DATA_PATTERN7   = DEF_PATTERN7,
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DQ_WIDTH    = 16,
  parameter int unsigned ERR_CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       read_en,
  input  logic                       pattern_en,
  input  logic [7:0]                 dq_inversion,
  input  logic                       err_clr,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  input  logic                       random_axi_ap,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]                 axi_aruser_id,
  output logic [3:0]                 axi_arlen,
  output logic                       axi_aruser_ap,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata,
  input  logic [3:0]                 axi_rid,
  input  logic                       axi_rlast,
  input  logic                       axi_rvalid,
  output logic                       read_done_p,
  output logic                       err_flag,
  output logic                       len_err,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  output logic [7:0]                 err_lane_mask,
  output logic [1:0]                 test_rd_state
);

  localparam int unsigned BEAT_W = MEM_DQ_WIDTH * 8;
  localparam int unsigned DQ_NUM = MEM_DQ_WIDTH / 8;
  localparam int unsigned GRP_W  = DQ_NUM * 8;

  rd_state_e   state;
  logic [3:0]  beat_cnt;
  logic        drain_cnt;

  logic        stray_beat;
  logic        data_beat;
  logic        last_beat;
  logic        len_evt;

  logic [7:0]        exp_grp [NUM_GROUPS];
  logic [BEAT_W-1:0] exp_beat;

  logic              s1_vld;
  logic [BEAT_W-1:0] s1_rdata;
  logic [BEAT_W-1:0] s1_exp;
  logic [7:0]        grp_mis;
  logic [7:0]        s2_mask;
  logic              new_err;

`ifdef RD_PRBS_CHK_EN
  logic [63:0] prbs_dout;
  logic        prbs_load;
  logic        prbs_adv;

  assign prbs_load = (state == ST_AR) && axi_arvalid && axi_arready;
  assign prbs_adv  = data_beat;

  prbs15_64bit_v1_0 u_prbs (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (prbs_load),
    .seed      (axi_araddr[15:0]),
    .advance   (prbs_adv),
    .prbs_dout (prbs_dout)
  );
`else
  // Only the low byte of the running beat address feeds the expected data
  logic [7:0] beat_addr;
`endif

  function automatic logic [7:0] pattern_byte(input int unsigned g);
    case (g)
      0:       return DATA_PATTERN0;
      1:       return DATA_PATTERN1;
      2:       return DATA_PATTERN2;
      3:       return DATA_PATTERN3;
      4:       return DATA_PATTERN4;
      5:       return DATA_PATTERN5;
      6:       return DATA_PATTERN6;
      default: return DATA_PATTERN7;
    endcase
  endfunction

  assign test_rd_state = state;

  // Classify the incoming beat and detect rlast/rid/stray protocol errors
  always_comb begin
    stray_beat = axi_rvalid && ((state == ST_IDLE) || (state == ST_AR));
    data_beat  = axi_rvalid && (state == ST_DATA);
    last_beat  = (beat_cnt == axi_arlen);
    len_evt    = stray_beat ||
                 (data_beat && ((axi_rlast != last_beat) || (axi_rid != axi_aruser_id)));
  end

  // Expected byte per lane group, then replicated across the DQ bytes of that group
  always_comb begin
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
`ifdef RD_PRBS_CHK_EN
      exp_grp[i] = (pattern_en ? pattern_byte(i) : prbs_dout[8*i +: 8]) ^ {8{dq_inversion[i]}};
`else
      exp_grp[i] = (pattern_en ? pattern_byte(i) : 8'(beat_addr + 8'(i))) ^ {8{dq_inversion[i]}};
`endif
    end
    exp_beat = '0;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      for (int unsigned j = 0; j < DQ_NUM; j++) begin
        exp_beat[(i*DQ_NUM+j)*8 +: 8] = exp_grp[i];
      end
    end
  end

  // Per-group compare of the stage-1 registered beat
  always_comb begin
    grp_mis = '0;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      grp_mis[i] = (s1_rdata[i*GRP_W +: GRP_W] != s1_exp[i*GRP_W +: GRP_W]);
    end
  end

  assign new_err = |s2_mask;

  // Burst FSM: latch fields, AR handshake, count beats, drain compare pipe, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      beat_cnt      <= '0;
      drain_cnt     <= 1'b0;
      axi_araddr    <= '0;
      axi_aruser_id <= '0;
      axi_arlen     <= '0;
      axi_aruser_ap <= 1'b0;
      axi_arvalid   <= 1'b0;
      read_done_p   <= 1'b0;
`ifndef RD_PRBS_CHK_EN
      beat_addr     <= '0;
`endif
    end else begin
      read_done_p <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_en) begin
            axi_araddr    <= random_rw_addr;
            axi_aruser_id <= random_axi_id;
            axi_arlen     <= random_axi_len;
            axi_aruser_ap <= random_axi_ap;
            axi_arvalid   <= 1'b1;
            state         <= ST_AR;
          end
        end
        ST_AR: begin
          if (axi_arvalid && axi_arready) begin
            axi_arvalid <= 1'b0;
            beat_cnt    <= '0;
`ifndef RD_PRBS_CHK_EN
            beat_addr   <= axi_araddr[7:0];
`endif
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi_rvalid) begin
`ifndef RD_PRBS_CHK_EN
            beat_addr <= beat_addr + 8'(BEAT_ADDR_STRIDE);
`endif
            if (last_beat) begin
              beat_cnt  <= '0;
              drain_cnt <= 1'b0;
              state     <= ST_CHK;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        ST_CHK: begin
          // Two drain cycles let the final beat's result reach the error status
          if (drain_cnt) begin
            read_done_p <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
      endcase
    end
  end

  // Compare pipeline: stage 1 holds data+expected, stage 2 holds the group mismatch mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_rdata <= '0;
      s1_exp   <= '0;
      s2_mask  <= '0;
    end else begin
      s1_vld   <= data_beat;
      s1_rdata <= axi_rdata;
      s1_exp   <= exp_beat;
      s2_mask  <= s1_vld ? grp_mis : '0;
    end
  end

  // Sticky error status; an error arriving together with err_clr survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag      <= 1'b0;
      len_err       <= 1'b0;
      err_cnt       <= '0;
      err_lane_mask <= '0;
    end else begin
      err_flag      <= new_err | (err_flag & ~err_clr);
      len_err       <= len_evt | (len_err & ~err_clr);
      err_lane_mask <= (err_clr ? '0 : err_lane_mask) | s2_mask;
      if (new_err) begin
        if (err_clr)
          err_cnt <= ERR_CNT_W'(1);
        else if (err_cnt != '1)
          err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else if (err_clr) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_test_rd_ctrl_chk.sv
// Self-checking bench for test_rd_ctrl_chk (default build: incrementing-address
// expected data). The error counter is narrowed so saturation is reachable quickly.
module tb_test_rd_ctrl_chk;

  localparam int unsigned AW   = 28;
  localparam int unsigned DQW  = 16;
  localparam int unsigned BW   = DQW * 8;
  localparam int unsigned ECW  = 6;
  localparam int unsigned MAXC = (1 << ECW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read_en, pattern_en, err_clr;
  logic [7:0]    dq_inversion;
  logic [AW-1:0] random_rw_addr;
  logic [3:0]    random_axi_id, random_axi_len;
  logic          random_axi_ap;
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_aruser_id, axi_arlen;
  logic          axi_aruser_ap, axi_arvalid, axi_arready;
  logic [BW-1:0] axi_rdata;
  logic [3:0]    axi_rid;
  logic          axi_rlast, axi_rvalid;
  logic          read_done_p, err_flag, len_err;
  logic [ECW-1:0] err_cnt;
  logic [7:0]    err_lane_mask;
  logic [1:0]    test_rd_state;

  int checks = 0;
  int errors = 0;

  // Reference model of the sticky status
  int unsigned m_cnt;
  logic [7:0]  m_lane;
  logic        m_flag, m_len;

  always #5 clk = ~clk;

  test_rd_ctrl_chk #(
    .CTRL_ADDR_WIDTH (AW),
    .MEM_DQ_WIDTH    (DQW),
    .ERR_CNT_W       (ECW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_en        (read_en),
    .pattern_en     (pattern_en),
    .dq_inversion   (dq_inversion),
    .err_clr        (err_clr),
    .random_rw_addr (random_rw_addr),
    .random_axi_id  (random_axi_id),
    .random_axi_len (random_axi_len),
    .random_axi_ap  (random_axi_ap),
    .axi_araddr     (axi_araddr),
    .axi_aruser_id  (axi_aruser_id),
    .axi_arlen      (axi_arlen),
    .axi_aruser_ap  (axi_aruser_ap),
    .axi_arvalid    (axi_arvalid),
    .axi_arready    (axi_arready),
    .axi_rdata      (axi_rdata),
    .axi_rid        (axi_rid),
    .axi_rlast      (axi_rlast),
    .axi_rvalid     (axi_rvalid),
    .read_done_p    (read_done_p),
    .err_flag       (err_flag),
    .len_err        (len_err),
    .err_cnt        (err_cnt),
    .err_lane_mask  (err_lane_mask),
    .test_rd_state  (test_rd_state)
  );

  function automatic logic [7:0] pat_byte(input int unsigned g);
    case (g % 4)
      0:       return 8'h55;
      1:       return 8'haa;
      2:       return 8'h7f;
      default: return 8'h80;
    endcase
  endfunction

  // Expected beat: group g byte = pattern or (addr low byte + g) mod 256, optionally inverted
  function automatic logic [BW-1:0] exp_beat(input logic [AW-1:0] a, input logic pat,
                                             input logic [7:0] inv);
    logic [BW-1:0] r;
    logic [7:0]    v;
    r = '0;
    for (int g = 0; g < 8; g++) begin
      v = pat ? pat_byte(g) : 8'((int'(a[7:0]) + g) % 256);
      if (inv[g]) v = ~v;
      for (int j = 0; j < 2; j++) r[(g*2+j)*8 +: 8] = v;
    end
    return r;
  endfunction

  function automatic void model_bad(input logic [BW-1:0] xm);
    m_cnt  = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
    m_flag = 1'b1;
    for (int g = 0; g < 8; g++) if (xm[g*16 +: 16] != '0) m_lane[g] = 1'b1;
  endfunction

  function automatic void model_clear();
    m_cnt = 0; m_lane = '0; m_flag = 1'b0; m_len = 1'b0;
  endfunction

  task automatic run_burst(input logic [AW-1:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic ap, input logic pat, input logic [7:0] inv,
                           input int rlast_at, input logic bad_rid, input logic [15:0] corrupt,
                           input logic [BW-1:0] xm, input int stall, input string tag);
    logic [BW-1:0] beat;
    int   waited;
    logic got, early;
    @(negedge clk);
    random_rw_addr = addr; random_axi_id = id; random_axi_len = len; random_axi_ap = ap;
    pattern_en = pat; dq_inversion = inv; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    random_rw_addr = AW'($urandom); random_axi_id = 4'($urandom);
    random_axi_len = 4'($urandom);  random_axi_ap = 1'($urandom);
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if ({axi_arvalid, axi_araddr, axi_aruser_id, axi_arlen, axi_aruser_ap} !== {1'b1, addr, id, len, ap}) begin
        errors++;
        $display("FAIL %s ar_hold cyc%0d: got v=%b a=%h id=%h len=%h ap=%b, want v=1 a=%h id=%h len=%h ap=%b",
                 tag, s, axi_arvalid, axi_araddr, axi_aruser_id, axi_arlen, axi_aruser_ap, addr, id, len, ap);
      end
      if (s == stall) axi_arready = 1'b1;
      @(negedge clk);
    end
    axi_arready = 1'b0;
    checks++;
    if (axi_arvalid !== 1'b0 || test_rd_state !== 2'd2) begin
      errors++;
      $display("FAIL %s ar_drop: got arvalid=%b state=%0d, want arvalid=0 state=2", tag, axi_arvalid, test_rd_state);
    end
    early = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      beat = exp_beat(addr + AW'(8*b), pat, inv);
      if (corrupt[b]) begin
        beat ^= xm;
        if (xm != '0) model_bad(xm);
      end
      axi_rvalid = 1'b1; axi_rdata = beat;
      axi_rid    = (bad_rid && b == 0) ? ~id : id;
      axi_rlast  = (b == rlast_at);
      @(negedge clk);
      if (b != int'(len) && read_done_p === 1'b1) early = 1'b1;
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    if (rlast_at != int'(len) || bad_rid) m_len = 1'b1;
    waited = 0; got = 1'b0;
    while (!got && waited < 8) begin
      if (read_done_p === 1'b1) got = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    checks++;
    if (!got || early) begin
      errors++;
      $display("FAIL %s done: got seen=%b early=%b, want seen=1 early=0", tag, got, early);
    end
    @(negedge clk);
    checks++;
    if (read_done_p !== 1'b0 || test_rd_state !== 2'd0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b state=%0d, want done=0 state=0", tag, read_done_p, test_rd_state);
    end
    checks++;
    if (err_cnt !== ECW'(m_cnt)) begin
      errors++; $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, m_cnt);
    end
    checks++;
    if (err_lane_mask !== m_lane) begin
      errors++; $display("FAIL %s lane_mask: got %h want %h", tag, err_lane_mask, m_lane);
    end
    checks++;
    if (err_flag !== m_flag) begin
      errors++; $display("FAIL %s err_flag: got %b want %b", tag, err_flag, m_flag);
    end
    checks++;
    if (len_err !== m_len) begin
      errors++; $display("FAIL %s len_err: got %b want %b", tag, len_err, m_len);
    end
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    model_clear();
    checks++;
    if ({err_flag, len_err, err_cnt, err_lane_mask} !== '0) begin
      errors++;
      $display("FAIL %s clr: got flag=%b len=%b cnt=%0d lane=%h, want all 0", tag, err_flag, len_err, err_cnt, err_lane_mask);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({axi_araddr, axi_aruser_id, axi_arlen, axi_aruser_ap, axi_arvalid, read_done_p,
         err_flag, len_err, err_cnt, err_lane_mask, test_rd_state} !== '0) begin
      errors++;
      $display("FAIL reset: got arvalid=%b state=%0d cnt=%0d flag=%b len=%b, want all 0",
               axi_arvalid, test_rd_state, err_cnt, err_flag, len_err);
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_pattern();
    run_burst(28'h100, 4'h3, 4'd3, 1'b0, 1'b1, 8'h00, 3, 1'b0, 16'h0, '0, 0, "pattern");
  endtask

  task automatic test_incr_bitflip();
    logic [BW-1:0] xm;
    run_burst(28'h40, 4'h1, 4'd0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 16'h0, '0, 0, "incr_ok");
    xm = '0; xm[0] = 1'b1;
    run_burst(28'h40, 4'h1, 4'd0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 16'h1, xm, 0, "incr_flip");
  endtask

  task automatic test_err_clr();
    do_clr("err_clr");
  endtask

  task automatic test_inversion();
    logic [BW-1:0] xm;
    run_burst(28'h200, 4'h5, 4'd1, 1'b0, 1'b1, 8'h80, 1, 1'b0, 16'h0, '0, 0, "inv_ok");
    xm = '0; xm[BW-1 -: 16] = 16'hffff;
    run_burst(28'h200, 4'h5, 4'd1, 1'b0, 1'b1, 8'h80, 1, 1'b0, 16'h1, xm, 0, "inv_bad");
    do_clr("inv");
  endtask

  task automatic test_len_err();
    run_burst(28'h80, 4'h2, 4'd1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 16'h0, '0, 0, "rlast_early");
    do_clr("len");
    run_burst(28'h88, 4'h9, 4'd2, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'h0, '0, 0, "rid_bad");
    do_clr("rid");
  endtask

  task automatic test_stray();
    @(negedge clk);
    axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rdata = {4{32'($urandom)}}; axi_rid = 4'h0;
    @(negedge clk);
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (len_err !== 1'b1 || err_cnt !== '0 || err_flag !== 1'b0 || test_rd_state !== 2'd0) begin
      errors++;
      $display("FAIL stray: got len=%b cnt=%0d flag=%b state=%0d, want len=1 cnt=0 flag=0 state=0",
               len_err, err_cnt, err_flag, test_rd_state);
    end
    do_clr("stray");
  endtask

  task automatic test_arready_stall();
    run_burst(28'hABC_DEF0, 4'hC, 4'd2, 1'b1, 1'b0, 8'h0F, 2, 1'b0, 16'h0, '0, 10, "stall");
  endtask

  task automatic test_random();
    logic [BW-1:0] xm;
    logic [3:0]    len;
    int            rl;
    for (int n = 0; n < 24; n++) begin
      len = 4'($urandom_range(0, 15));
      rl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'(len);
      xm  = '0;
      xm[$urandom_range(0, 15)*8 +: 8] = 8'($urandom_range(1, 255));
      run_burst(AW'($urandom), 4'($urandom), len, 1'($urandom), 1'($urandom), 8'($urandom),
                rl, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0,
                xm, int'($urandom_range(0, 3)), "random");
      if (n % 6 == 5) do_clr("random");
    end
  endtask

  task automatic test_saturation();
    logic [BW-1:0] xm;
    do_clr("sat_pre");
    for (int n = 0; n < 5; n++) begin
      xm = '0;
      xm[$urandom_range(0, 15)*8 +: 8] = 8'($urandom_range(1, 255));
      run_burst(AW'($urandom), 4'h7, 4'd15, 1'b0, 1'b0, 8'h00, 15, 1'b0, 16'hffff, xm, 0, "sat");
    end
    checks++;
    if (err_cnt !== '1) begin
      errors++; $display("FAIL saturate: got %0d want %0d", err_cnt, MAXC);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    random_rw_addr = 28'h300; random_axi_id = 4'h3; random_axi_len = 4'd4; random_axi_ap = 1'b1;
    pattern_en = 1'b0; dq_inversion = 8'h00; read_en = 1'b1;
    @(negedge clk); read_en = 1'b0; axi_arready = 1'b1;
    @(negedge clk); axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rid = 4'h3; axi_rlast = 1'b0; axi_rdata = ~exp_beat(28'h300, 1'b0, 8'h00);
    @(negedge clk); axi_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axi_araddr, axi_aruser_id, axi_arlen, axi_aruser_ap, axi_arvalid, read_done_p,
         err_flag, len_err, err_cnt, err_lane_mask, test_rd_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got arvalid=%b state=%0d cnt=%0d flag=%b len=%b, want all 0",
               axi_arvalid, test_rd_state, err_cnt, err_flag, len_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({err_flag, err_cnt, err_lane_mask, test_rd_state} !== '0) begin
      errors++;
      $display("FAIL reset_drain: got cnt=%0d flag=%b state=%0d, want 0", err_cnt, err_flag, test_rd_state);
    end
    rst_n = 1'b1;
    model_clear();
    run_burst(28'h310, 4'h6, 4'd3, 1'b0, 1'b0, 8'h3C, 3, 1'b0, 16'h0, '0, 0, "post_reset");
  endtask

  initial begin
    rst_n = 1'b0; read_en = 1'b0; pattern_en = 1'b0; err_clr = 1'b0; dq_inversion = '0;
    random_rw_addr = '0; random_axi_id = '0; random_axi_len = '0; random_axi_ap = 1'b0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rid = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    model_clear();
    test_reset();
    test_pattern();
    test_incr_bitflip();
    test_err_clr();
    test_inversion();
    test_len_err();
    test_stray();
    test_arready_stall();
    test_random();
    test_saturation();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
